// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding. The transmitter
// takes its baud constant from here as well, so both ends stay matched.
package uart_pkg;

    localparam int BAUD_CLKS = 43;
    localparam int HALF_CLKS = BAUD_CLKS / 2;

    localparam int BAUD_CNT_W = 6;
    localparam int BIT_CNT_W  = 3;

    // Terminal counts for the == comparisons in the receiver.
    localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_CLKS - 1);
    localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(HALF_CLKS - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = '1;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_WAIT_HI = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input. The reset value
// is a parameter so idle-high lines do not look active out of reset.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples the synchronized line at mid-bit, presents each
// good byte on a sticky rdy flag with a clear handshake, and pulses
// frame_err / overrun for one cycle on the stop-sample edge.
module uart_rx
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun
);

    logic                  rx_s;
    rx_state_e             state_q, state_d;
    logic [BAUD_CNT_W-1:0] baud_q, baud_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            data_q, data_d;
    logic                  rdy_q, rdy_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic                  baud_tick;
    logic                  half_tick;

    sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (RX),
        .q_o   (rx_s)
    );

    assign baud_tick = (baud_q == BAUD_LAST);
    assign half_tick = (baud_q == HALF_LAST);

    // Register all receiver state and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state, counter, shift and flag logic for the receive FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned and infers a latch.
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        rdy_d   = rdy_q & ~clr_rdy;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    baud_d  = '0;
                    state_d = RX_START;
                end
            end

            RX_START: begin
                if (half_tick) begin
                    if (rx_s) begin
                        // Line went back high before mid-start: a glitch.
                        state_d = RX_IDLE;
                    end else begin
                        baud_d  = '0;
                        bit_d   = '0;
                        state_d = RX_DATA;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            RX_DATA: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            RX_STOP: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (rx_s) begin
                        // A completing byte wins over a same-edge clear.
                        data_d  = shift_q;
                        rdy_d   = 1'b1;
                        ovr_d   = rdy_q & ~clr_rdy;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_WAIT_HI;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            RX_WAIT_HI: begin
                // Hold off until a break or stuck-low line releases.
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end

            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign rx_data   = data_q;
    assign rdy       = rdy_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected byte events into a
// queue, and a negedge monitor pops and compares whenever the receiver shows
// a new byte, an overrun or a framing error.
module tb_uart_rx;

    localparam int BAUD = 43;
    // Drive at cycle k (just after a posedge) -> stop-sample edge at k+411.
    localparam int LAT  = 411;

    typedef struct {
        logic [7:0] data;
        logic       rdy;
        logic       fe;
        logic       ov;
        int         due;
    } evt_t;

    logic       clk;
    logic       rst_n;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frame_err;
    logic       overrun;

    int   cyc;
    int   checks;
    int   errors;
    evt_t sb_q[$];

    logic       prev_rdy;
    logic [7:0] prev_data;

    uart_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .clr_rdy   (clr_rdy),
        .rx_data   (rx_data),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_evt(input logic [7:0] d, input logic r, input logic fe,
                            input logic ov, input int due);
        evt_t e;
        e.data = d;
        e.rdy  = r;
        e.fe   = fe;
        e.ov   = ov;
        e.due  = due;
        sb_q.push_back(e);
    endtask

    // Serial 8N1 frame, LSB first, with a selectable stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        RX = 1'b0;
        wait_cyc(BAUD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            wait_cyc(BAUD);
        end
        RX = stop_val;
        wait_cyc(BAUD);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 1000) begin
            wait_cyc(1);
            n++;
        end
        check(name, sb_q.size(), 0);
    endtask

    // Monitor: any visible byte event pops one expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rdy  = rdy;
            prev_data = rx_data;
        end else begin
            if ((rdy && !prev_rdy) || overrun || frame_err || (rx_data != prev_data)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: rdy=%b data=%h fe=%b ov=%b at cycle %0d, expected no event",
                             rdy, rx_data, frame_err, overrun, cyc);
                end else begin
                    evt_t e;
                    e = sb_q.pop_front();
                    check("evt_cycle", cyc, e.due);
                    check("evt_data", rx_data, e.data);
                    check("evt_rdy", rdy, e.rdy);
                    check("evt_frame_err", frame_err, e.fe);
                    check("evt_overrun", overrun, e.ov);
                end
            end
            prev_rdy  = rdy;
            prev_data = rx_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        RX      = 1'b1;
        clr_rdy = 1'b0;
        wait_cyc(3);
        check("reset_rdy", rdy, 1'b0);
        check("reset_data", rx_data, 8'h00);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        wait_cyc(5);

        // Clean byte.
        push_evt(8'hA5, 1'b1, 1'b0, 1'b0, cyc + LAT);
        send_frame(8'hA5, 1'b1);
        drain("drain_a5");
        clr_rdy = 1'b1;
        wait_cyc(1);
        clr_rdy = 1'b0;
        check("clr_rdy_clears", rdy, 1'b0);
        wait_cyc(20);

        // 10-clock low glitch is rejected at the mid-start sample.
        RX = 1'b0;
        wait_cyc(10);
        RX = 1'b1;
        wait_cyc(500);
        check("glitch_rdy", rdy, 1'b0);
        check("glitch_data", rx_data, 8'hA5);

        // Back-to-back frames, no clear: second one overruns.
        push_evt(8'h00, 1'b1, 1'b0, 1'b0, cyc + LAT);
        push_evt(8'hFF, 1'b1, 1'b0, 1'b1, cyc + 10 * BAUD + LAT);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drain("drain_b2b");
        wait_cyc(20);
        check("b2b_rdy_sticky", rdy, 1'b1);

        // clr_rdy on the exact completion edge: byte wins, no overrun.
        push_evt(8'h5A, 1'b1, 1'b0, 1'b0, cyc + LAT);
        fork
            send_frame(8'h5A, 1'b1);
            begin
                wait_cyc(LAT - 1);
                clr_rdy = 1'b1;
                wait_cyc(1);
                clr_rdy = 1'b0;
            end
        join
        drain("drain_5a");
        check("clr_same_edge_rdy", rdy, 1'b1);
        wait_cyc(20);

        // Stop bit low, line held low afterwards: one frame_err only.
        push_evt(8'h5A, 1'b1, 1'b1, 1'b0, cyc + LAT);
        send_frame(8'h3C, 1'b0);
        wait_cyc(300);
        RX = 1'b1;
        drain("drain_3c");
        check("ferr_data_kept", rx_data, 8'h5A);
        check("ferr_rdy_kept", rdy, 1'b1);
        wait_cyc(100);

        // Reset mid-DATA of 8'hC3; sender aborts with the reset.
        RX = 1'b0;
        wait_cyc(BAUD);
        for (int i = 0; i < 3; i++) begin
            RX = (8'hC3 >> i) & 8'h01;
            wait_cyc(BAUD);
        end
        RX = 1'b0;
        wait_cyc(20);
        rst_n = 1'b0;
        RX    = 1'b1;
        #2;
        check("async_rst_rdy", rdy, 1'b0);
        check("async_rst_data", rx_data, 8'h00);
        check("async_rst_frame_err", frame_err, 1'b0);
        check("async_rst_overrun", overrun, 1'b0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(600);
        check("no_partial_rdy", rdy, 1'b0);

        // Clean frame after the reset.
        push_evt(8'h81, 1'b1, 1'b0, 1'b0, cyc + LAT);
        send_frame(8'h81, 1'b1);
        drain("drain_81");
        wait_cyc(200);
        check("final_queue_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the 8N1 link driven by the design's UART transmitter. It sits directly downstream of the transmitter's TX line, in loopback or across the board link, and recovers bytes for the command/response logic. The line is sampled at mid-bit using the same 43-clock baud period. Each byte is presented on a sticky ready flag with an explicit clear handshake, and framing and overrun errors are reported.

## Interface
- BAUD_CLKS, 43, clocks per bit; must match the transmitter.
- HALF_CLKS, 21, clocks from start-bit detection to the mid-start sample, equal to BAUD_CLKS/2 rounded down.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- RX  in  1  serial line, asynchronous to clk; idles high.
- clr_rdy  in  1  consumer acknowledge; clears rdy.
- rx_data  out  8  last good byte received; reset 8'h00.
- rdy  out  1  sticky flag: a new byte is in rx_data; reset 0.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low; reset 0.
- overrun  out  1  one-cycle pulse when a good byte completes while rdy is already 1; reset 0.

## Operation
- RX passes through a 2-flop synchronizer whose flops reset to 1. The output is rx_s, and all logic uses rx_s only.
- States are IDLE, START, DATA, STOP and WAIT_HI. Reset state is IDLE, with the baud counter, bit counter and shift register cleared.
- IDLE: when rx_s==0, clear the baud counter and go to START.
- START: count HALF_CLKS clocks, then sample rx_s.
  - If the sample is 1, it was a false start: go to IDLE.
  - If the sample is 0, clear the baud counter and the bit counter, then go to DATA.
- DATA: every BAUD_CLKS clocks, sample rx_s into the shift register MSB and shift right, so the byte is received LSB first. After the 8th sample, go to STOP.
- STOP: BAUD_CLKS clocks after the bit-7 sample, sample rx_s.
  - If the sample is 1: load rx_data from the shift register and set rdy. If rdy was already 1 on that edge and clr_rdy is 0, pulse overrun; the new byte still overwrites rx_data. Go to IDLE.
  - If the sample is 0: pulse frame_err, leave rx_data and rdy unchanged, and go to WAIT_HI.
- WAIT_HI: stay until rx_s==1, then go to IDLE. This prevents a break or low line from being taken as a new start bit.
- rdy handling:
  - clr_rdy clears rdy on the next edge.
  - A byte completing on the same edge as clr_rdy takes priority: rdy stays 1 and overrun is not pulsed.
- Unused state encodings go to IDLE.

## Timing
- Sync latency: 2 clocks from the RX edge to the rx_s edge.
- Let edge E be the edge on which IDLE sees rx_s==0. Sample points are:
  - mid-start at E+21;
  - bit n (n=0..7) at E+21+43·(n+1);
  - stop at E+408.
- rdy, rx_data, frame_err and overrun update on the stop-sample edge.
- A byte from the transmitter reaches rdy about 411 clocks after the transmitter's start-bit TX edge.
- Back-to-back transmitter frames (STOP→START with no idle) must be received without loss. After a good stop sample, IDLE is re-entered at E+409, about 20 clocks before the next start edge reaches rx_s.
- Asynchronous reset mid-frame:
  - all outputs return to their reset values immediately and the state goes to IDLE;
  - after reset release, a low line is treated as a start, so reception can resynchronise only on a later idle-to-start edge. The partially received byte is never reported.

## Structure
- The shared package uart_pkg holds BAUD_CLKS, HALF_CLKS and the rx state enum. The transmitter takes its baud constant from the same package.
- Sub-module sync2: a 2-flop synchronizer with a reset-value parameter (1 here). It is reused for other asynchronous inputs.
- Counters:
  - 6-bit baud counter, compared with == against BAUD_CLKS-1 and HALF_CLKS-1;
  - 3-bit bit counter, where all-ones plus a baud tick means the last bit.

## Test plan
- Transmitter loopback sends 8'hA5 → rdy rises at the stop-sample edge, rx_data==8'hA5, no frame_err.
- An RX low glitch of 10 clocks, then high → no state beyond START, rdy stays 0, back in IDLE by E+22.
- Hand-driven frame 8'h3C with the stop bit held low → one-cycle frame_err, rx_data and rdy unchanged, no new start until the line returns high.
- Back-to-back transmitter frames 8'h00 then 8'hFF with no clr_rdy → both received, overrun pulses once on the second, rx_data==8'hFF.
- clr_rdy asserted on the exact completion edge of 8'h5A → rdy stays 1, no overrun, rx_data==8'h5A.
- rst_n pulsed low mid-DATA of 8'hC3 → outputs reset at once, the partial byte is never flagged, and the next clean frame 8'h81 is received correctly.
